// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential restoring divider: state encodings,
// default widths and the divide-by-zero quotient constant.
package seq_divider_32_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 5;

  localparam logic [DEF_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_32_div_step.sv
// One restoring-division iteration: shift {rem, quo}, trial subtract at
// WIDTH+1 bits, keep the difference or restore.
module seq_divider_32_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor_mag};

  // rem < divisor_mag always holds, so a non-negative trial fits in WIDTH bits
  always_comb begin
    if (!trial[WIDTH]) begin
      next_rem = trial[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], 1'b1};
    end else begin
      next_rem = rem_sh[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle signed/unsigned restoring divider for MIPS DIV/DIVU.
// quotient feeds LO, remainder feeds HI; done pulses once per divide.
module seq_divider_32
  import seq_divider_32_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag, step_rem, step_quo;
  logic             divisor_zero;

  assign divisor_zero = (divisor == '0);
  assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  seq_divider_32_div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dmag_q),
    .next_rem    (step_rem),
    .next_quo    (step_quo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = divisor_zero ? FIX : CALC;
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

  // Divide-by-zero preloads the final raw values so FIX treats both paths alike
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          if (divisor_zero) begin
            quo_d   = WIDTH'(DIV0_QUOTIENT);
            rem_d   = dividend;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            zero_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            quo_d   = dvd_mag;
            rem_d   = '0;
            dmag_d  = dvs_mag;
            q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = is_signed && dividend[WIDTH-1];
            zero_d  = 1'b0;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dbz_d       = zero_q;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

endmodule
